// File: rtl/mem_reg_mp.sv
// rtl/mem_reg_mp.sv - register bank with sweep-clear FSM and saturating accumulators
module mem_reg_mp #(
    parameter int W       = 24,
    parameter int NR      = 32,
    parameter int ADDRW   = 5,
    parameter int NACC    = 2,
    parameter int FORWARD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [ADDRW-1:0]  dira,
    input  logic [ADDRW-1:0]  dirb,
    input  logic [W-1:0]      data,
    output logic [W-1:0]      A,
    output logic [W-1:0]      B,
    input  logic [NACC-1:0]   acc_we,
    input  logic [NACC-1:0]   acc_add,
    input  logic [NACC*W-1:0] acc_d,
    output logic [NACC*W-1:0] acc_q,
    output logic [NACC-1:0]   acc_ovf,
    input  logic [NACC-1:0]   acc_ovf_clr,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);
    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDRW-1:0] LAST   = ADDRW'(NR - 1);
    localparam logic [ADDRW:0]   NR_LIM = (ADDRW + 1)'(NR);
    localparam logic [W-1:0]     SMAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SMIN   = {1'b1, {(W-1){1'b0}}};

    state_t               state_q, state_d;
    logic [ADDRW-1:0]     cnt_q, cnt_d;
    logic [W-1:0]         mem_q [NR];
    logic [W-1:0]         mem_d [NR];
    logic [NACC*W-1:0]    acc_q_q, acc_q_d;
    logic [NACC-1:0]      ovf_q, ovf_d;

    logic a_ok, b_ok;
    assign a_ok = {1'b0, dira} < NR_LIM;
    assign b_ok = {1'b0, dirb} < NR_LIM;

    assign busy     = (state_q == CLEAR);
    assign clr_done = busy && (cnt_q == LAST) && !rst;
    assign acc_q    = acc_q_q;
    assign acc_ovf  = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (clr_start) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        end else if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) mem_d[i] = mem_q[i];
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
        end else if (write && a_ok) begin
            mem_d[dira] = data;
        end
    end

    // Port B forwards in-range IDLE writes only; port A always shows the stored value.
    always_comb begin
        A = '0;
        B = '0;
        if (!busy) begin
            if (a_ok) A = mem_q[dira];
            if (b_ok) begin
                if (FORWARD != 0 && write && dirb == dira) B = data;
                else                                       B = mem_q[dirb];
            end
        end
    end

    always_comb begin
        logic [W-1:0] a, b, s;
        acc_q_d = acc_q_q;
        ovf_d   = ovf_q & ~acc_ovf_clr;
        for (int k = 0; k < NACC; k++) begin
            a = acc_q_q[k*W +: W];
            b = acc_d[k*W +: W];
            s = a + b;
            if (acc_we[k]) begin
                if (!acc_add[k]) begin
                    acc_q_d[k*W +: W] = b;
                end else if (!a[W-1] && !b[W-1] && s[W-1]) begin
                    acc_q_d[k*W +: W] = SMAX;
                    ovf_d[k]          = 1'b1;
                end else if (a[W-1] && b[W-1] && !s[W-1]) begin
                    acc_q_d[k*W +: W] = SMIN;
                    ovf_d[k]          = 1'b1;
                end else begin
                    acc_q_d[k*W +: W] = s;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            acc_q_q <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q_q <= acc_q_d;
            ovf_q   <= ovf_d;
            for (int i = 0; i < NR; i++) mem_q[i] <= mem_d[i];
        end
    end
endmodule

// File: tb/tb_mem_reg_mp.sv
// tb/tb_mem_reg_mp.sv - directed self-checking bench for mem_reg_mp
module tb_mem_reg_mp;
    localparam int W = 24, NR = 32, ADDRW = 5, NACC = 2;

    logic              clk = 1'b0;
    logic              rst, write, clr_start;
    logic [ADDRW-1:0]  dira, dirb;
    logic [W-1:0]      data, A, B;
    logic [NACC-1:0]   acc_we, acc_add, acc_ovf, acc_ovf_clr;
    logic [NACC*W-1:0] acc_d, acc_q;
    logic              busy, clr_done;

    int n_checks = 0;
    int n_fail   = 0;

    mem_reg_mp #(.W(W), .NR(NR), .ADDRW(ADDRW), .NACC(NACC), .FORWARD(1)) dut (
        .clk(clk), .rst(rst), .write(write), .dira(dira), .dirb(dirb), .data(data),
        .A(A), .B(B), .acc_we(acc_we), .acc_add(acc_add), .acc_d(acc_d), .acc_q(acc_q),
        .acc_ovf(acc_ovf), .acc_ovf_clr(acc_ovf_clr), .clr_start(clr_start),
        .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep from its first busy cycle; optionally hammers a write to addr 7.
    task automatic measure_sweep(input string tag, input bit wr7);
        int nb = 0, np = 0, at = 0;
        if (wr7) begin
            write = 1'b1; dira = 5'd7; dirb = 5'd7; data = 24'h55AA55;
        end
        for (int i = 0; i < 40; i++) begin
            if (!busy && nb > 0) break;
            if (busy) begin
                nb++;
                if (A != 0 || B != 0) np += 100;
                if (clr_done) begin np++; at = nb; end
            end
            step();
        end
        write = 1'b0;
        check({tag, "_busy_cycles"}, 64'(nb), 64'd32);
        check({tag, "_done_pulses"}, 64'(np), 64'd1);
        check({tag, "_done_last"},   64'(at), 64'd32);
    endtask

    initial begin
        int bad;
        rst = 1'b1; write = 1'b0; clr_start = 1'b0; dira = '0; dirb = '0; data = '0;
        acc_we = '0; acc_add = '0; acc_d = '0; acc_ovf_clr = '0;
        step();
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_acc_q", 64'(acc_q), 64'd0);
        check("rst_acc_ovf", 64'(acc_ovf), 64'd0);
        measure_sweep("sweep1", 1'b1);

        bad = 0;
        for (int i = 0; i < NR; i++) begin
            dira = ADDRW'(i); dirb = ADDRW'(i); #1;
            if (A != 0 || B != 0) bad++;
        end
        check("all_zero", 64'(bad), 64'd0);
        dira = 5'd7; dirb = 5'd7; #1;
        check("addr7_dropped", 64'(A), 64'd0);

        write = 1'b1; dira = 5'd5; dirb = 5'd5; data = 24'h123456; #1;
        check("fwd_B", 64'(B), 64'h123456);
        check("old_A", 64'(A), 64'd0);
        step();
        write = 1'b0; #1;
        check("new_A", 64'(A), 64'h123456);
        write = 1'b1; dira = 5'd6; dirb = 5'd5; data = 24'hABCDEF; #1;
        check("nofwd_B", 64'(B), 64'h123456);
        step();
        write = 1'b0; dira = 5'd6; #1;
        check("addr6_A", 64'(A), 64'hABCDEF);

        acc_we = 2'b01; acc_add = 2'b00; acc_d = {24'd0, 24'h7FFFF0};
        step();
        check("acc0_load", 64'(acc_q[23:0]), 64'h7FFFF0);
        acc_add = 2'b01; acc_d = {24'd0, 24'h000020};
        step();
        check("acc0_sat", 64'(acc_q[23:0]), 64'h7FFFFF);
        check("acc0_ovf", 64'(acc_ovf[0]), 64'd1);
        acc_we = 2'b00; acc_ovf_clr = 2'b01;
        step();
        acc_ovf_clr = 2'b00;
        check("acc0_ovf_clr", 64'(acc_ovf[0]), 64'd0);
        check("acc0_hold", 64'(acc_q[23:0]), 64'h7FFFFF);

        acc_we = 2'b10; acc_add = 2'b00; acc_d = {24'h800005, 24'd0};
        step();
        acc_add = 2'b10; acc_d = {24'hFFFFF0, 24'd0};
        step();
        check("acc1_sat", 64'(acc_q[47:24]), 64'h800000);
        check("acc1_ovf", 64'(acc_ovf), 64'b10);
        check("acc0_indep", 64'(acc_q[23:0]), 64'h7FFFFF);

        acc_we = 2'b11; acc_add = 2'b11; acc_d = {24'hFFFFF0, 24'hFFFFFF}; acc_ovf_clr = 2'b10;
        step();
        acc_we = 2'b00; acc_ovf_clr = 2'b00;
        check("acc0_add_neg", 64'(acc_q[23:0]), 64'h7FFFFE);
        check("acc1_set_prio", 64'(acc_ovf), 64'b10);
        check("acc1_pinned", 64'(acc_q[47:24]), 64'h800000);

        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 10; i++) step();
        check("mid_no_done", 64'(clr_done), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_acc_q", 64'(acc_q), 64'd0);
        measure_sweep("sweep2", 1'b0);
        dira = 5'd5; #1;
        check("post_sweep_A5", 64'(A), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_reg_mp.md
MEM_REG_MP -- requirements
Module: mem_reg_mp

Interface
REQ-001 SHALL have parameter W, default 24, data width in bits.
REQ-002 SHALL have parameter NR, default 32, number of Data Bank registers (NR >= 2).
REQ-003 SHALL have parameter ADDRW, default 5, address width (2**ADDRW >= NR).
REQ-004 SHALL have parameter NACC, default 2, number of accumulator channels (channel 0 = RQ role, channel 1 = RD role).
REQ-005 SHALL have parameter FORWARD, default 1, enabling write-through on read port B.
REQ-006 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port write  input  1  Data Bank write enable.
REQ-009 SHALL have port dira  input  ADDRW  shared write and read-A address.
REQ-010 SHALL have port dirb  input  ADDRW  read-B address.
REQ-011 SHALL have port data  input  W  write data.
REQ-012 SHALL have port A  output  W  combinational read port A.
REQ-013 SHALL have port B  output  W  combinational read port B.
REQ-014 SHALL have port acc_we  input  NACC  per-channel accumulator enable.
REQ-015 SHALL have port acc_add  input  NACC  per-channel mode: 0 = load, 1 = saturating accumulate.
REQ-016 SHALL have port acc_d  input  NACC*W  packed operands; channel k in bits [k*W +: W].
REQ-017 SHALL have port acc_q  output  NACC*W  packed accumulator values, same packing.
REQ-018 SHALL have port acc_ovf  output  NACC  sticky per-channel saturation flag.
REQ-019 SHALL have port acc_ovf_clr  input  NACC  per-channel clear of acc_ovf.
REQ-020 SHALL have port clr_start  input  1  request a full bank clear.
REQ-021 SHALL have port busy  output  1  high while the clear sweep runs.
REQ-022 SHALL have port clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-023 SHALL implement a two-state FSM: IDLE and CLEAR; busy = (state == CLEAR).
REQ-024 SHALL enter CLEAR on rst with sweep counter = 0; CLEAR writes zero to mem[counter] every cycle, incrementing the counter.
REQ-025 SHALL, in the CLEAR cycle with counter == NR-1, write zero, assert clr_done for that cycle only, and return to IDLE on the next edge (sweep = NR cycles).
REQ-026 SHALL move IDLE -> CLEAR when clr_start = 1 and reset counter to 0; clr_start during CLEAR is ignored.
REQ-027 SHALL, in IDLE only, write data into mem[dira] on the edge when write = 1; writes during CLEAR are discarded.
REQ-028 SHALL drive A = mem[dira] with no forwarding, so a same-cycle read-modify-write reads the old value.
REQ-029 SHALL drive B = data when FORWARD = 1, state = IDLE, write = 1 and dirb == dira; otherwise B = mem[dirb].
REQ-030 SHALL drive A and B to 0 while busy = 1.
REQ-031 SHALL return 0 on A or B for an address >= NR; a write to such an address is discarded.
REQ-032 SHALL, per channel k with acc_we[k] = 1: load acc_q[k] <= acc_d[k] if acc_add[k] = 0; else acc_q[k] <= sat(acc_q[k] + acc_d[k]), a signed two's-complement W-bit sum.
REQ-033 SHALL saturate at +(2**(W-1))-1 on positive overflow and -(2**(W-1)) on negative overflow, and set acc_ovf[k] on the same edge.
REQ-034 SHALL give set priority over clear when acc_ovf_clr[k] and a new overflow occur in the same cycle.
REQ-035 SHALL keep the accumulators independent of the FSM; they operate during CLEAR.
REQ-036 SHALL make the accumulator result visible on acc_q one cycle after the enabling edge.

Reset
REQ-037 SHALL, on rst, set acc_q = 0, acc_ovf = 0, clr_done = 0, state = CLEAR (busy = 1 on the following cycle); rst has priority over all inputs.
REQ-038 SHALL restart the sweep from address 0 if rst is asserted mid-sweep.

Verification
REQ-039 SHALL verify: rst 1 cycle -> busy = 1 for exactly 32 cycles, clr_done pulses once in the last of them, and every address then reads 0 on A and B.
REQ-040 SHALL verify: IDLE, write = 1, dira = dirb = 5, data = 0x123456 -> B = 0x123456 in the same cycle, A = 0 (old value); the next cycle A = 0x123456.
REQ-041 SHALL verify: acc0 load 0x7FFFF0, then add 0x000020 -> acc_q[0] = 0x7FFFFF and acc_ovf[0] = 1; acc_ovf_clr[0] pulse -> 0.
REQ-042 SHALL verify: acc1 load 0x800005, add 0xFFFFF0 (-16) -> acc_q[1] = 0x800000 and acc_ovf[1] = 1; acc0 is unchanged.
REQ-043 SHALL verify: a write to addr 7 issued while busy = 1 is dropped -> mem[7] = 0 after the sweep.
REQ-044 SHALL verify: rst asserted at sweep counter = 10 -> the sweep restarts at 0 and completes 32 cycles later with clr_done.
